// File: rtl/dmem_arbiter_pkg.sv
// dmem_arbiter_pkg: grant FSM state encodings and port identifiers
// Shared by the arbiter and future memory-side controllers.
package dmem_arbiter_pkg;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } state_t;
  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;
endpackage

// File: rtl/dmem_arb_perf.sv
// dmem_arb_perf: saturating grant and conflict counters for dmem_arbiter
// Only compiled when DMEM_ARB_PERF_EN is defined.
`ifdef DMEM_ARB_PERF_EN
module dmem_arb_perf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        gnt0,
  input  logic        gnt1,
  input  logic        conflict,
  output logic [31:0] perf_gnt0,
  output logic [31:0] perf_gnt1,
  output logic [31:0] perf_conflict
);
  logic [31:0] r_gnt0, r_gnt1, r_conflict;
  assign perf_gnt0 = r_gnt0;
  assign perf_gnt1 = r_gnt1;
  assign perf_conflict = r_conflict;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt0 <= '0;
      r_gnt1 <= '0;
      r_conflict <= '0;
    end else begin
      if (gnt0 && ~&r_gnt0) r_gnt0 <= r_gnt0 + 32'd1;
      if (gnt1 && ~&r_gnt1) r_gnt1 <= r_gnt1 + 32'd1;
      if (conflict && ~&r_conflict) r_conflict <= r_conflict + 32'd1;
    end
  end
endmodule
`endif

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port registered-grant arbiter in front of the CPU data memory
// Define DMEM_ARB_PERF_EN to add the perf_gnt0/perf_gnt1/perf_conflict counters.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wd0,
  input  logic [DW-1:0] wd1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          rvalid0,
  output logic          rvalid1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wd,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rd
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [31:0]   perf_gnt0,
  output logic [31:0]   perf_gnt1,
  output logic [31:0]   perf_conflict
`endif
);
  state_t r_state, w_next;
  logic r_last, r_rvalid0, r_rvalid1, w_pick1;
  logic [DW-1:0] r_rdata0, r_rdata1;
  assign gnt0 = (r_state == ST_GNT0);
  assign gnt1 = (r_state == ST_GNT1);
  assign rvalid0 = r_rvalid0;
  assign rvalid1 = r_rvalid1;
  assign rdata0 = r_rdata0;
  assign rdata1 = r_rdata1;
  assign mem_addr = gnt0 ? addr0 : gnt1 ? addr1 : '0;
  assign mem_wd = gnt0 ? wd0 : gnt1 ? wd1 : '0;
  assign mem_we = (gnt0 & we0) | (gnt1 & we1);
  // A granted port is excluded next cycle, so the other port never starves even with fixed priority
  always_comb begin
    w_pick1 = req1 & (~req0 | ((FIXED_PRIO == 0) && (r_last == PORT0)));
    w_next = gnt0 ? (req1 ? ST_GNT1 : ST_IDLE) :
             gnt1 ? (req0 ? ST_GNT0 : ST_IDLE) :
             w_pick1 ? ST_GNT1 : req0 ? ST_GNT0 : ST_IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_last <= PORT0;
      r_rvalid0 <= 1'b0;
      r_rvalid1 <= 1'b0;
      r_rdata0 <= '0;
      r_rdata1 <= '0;
    end else begin
      r_state <= w_next;
      r_last <= gnt1 ? PORT1 : gnt0 ? PORT0 : r_last;
      r_rvalid0 <= gnt0 & ~we0;
      r_rvalid1 <= gnt1 & ~we1;
      if (gnt0 & ~we0) r_rdata0 <= mem_rd;
      if (gnt1 & ~we1) r_rdata1 <= mem_rd;
    end
  end
`ifdef DMEM_ARB_PERF_EN
  dmem_arb_perf u_perf (
    .clk           (clk),
    .rst_n         (rst_n),
    .gnt0          (gnt0),
    .gnt1          (gnt1),
    .conflict      (req0 & req1),
    .perf_gnt0     (perf_gnt0),
    .perf_gnt1     (perf_gnt1),
    .perf_conflict (perf_conflict)
  );
`endif
endmodule
